pipe_issue_unit: RTL and testbench

Front-end instruction issuer for the 4-stage register-to-memory ALU pipeline (stages: reg read, ALU, regbank write, membank write). It accepts instructions over a valid/ready interface, buffers them in a small FIFO, and drives the pipeline's rs1/rs2/rd/func/addr inputs one instruction per cycle. The pipeline has no forwarding, so the block holds a read-after-write scoreboard and inserts bubbles when a source register is still in flight.

---
 rtl/pipe_pkg.sv | 45 ++++
 rtl/pipe_instr_fifo.sv | 69 ++++++
 rtl/pipe_issue_unit.sv | 125 ++++++++++++
 tb/tb_pipe_issue_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the ALU pipeline issue unit
//
// Purpose: opcode enum, instruction word, scoreboard entry and widths
// used by pipe_issue_unit and pipe_instr_fifo.
// Ports: none (package).
package pipe_pkg;

  localparam int REG_W  = 4;
  localparam int ADDR_W = 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_SELA = 4'd3,
    OP_SELB = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NEGA = 4'd8,
    OP_NEGB = 4'd9,
    OP_SRA  = 4'd10,
    OP_SLA  = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    alu_op_e           func;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
  } sb_entry_t;

  // True when an in-flight destination matches either source operand.
  function automatic logic sb_hit(sb_entry_t e, logic [REG_W-1:0] a,
                                  logic [REG_W-1:0] b);
    return e.v && ((e.rd == a) || (e.rd == b));
  endfunction

endpackage

// File: rtl/pipe_instr_fifo.sv
// rtl/pipe_instr_fifo.sv - synchronous instruction FIFO with flush
//
// Purpose: buffers instr_t words between the issue interface and the
// issue stage.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push, wdata        write request / data (ignored when full or flushing)
//   pop, rdata         read request / head entry (ignored when empty or flushing)
//   flush              empties the FIFO on this edge
//   full, empty, count occupancy status
module pipe_instr_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  instr_t                   wdata,
  output instr_t                   rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  instr_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pipe_issue_unit.sv
// rtl/pipe_issue_unit.sv - RAW-aware instruction issuer for the ALU pipeline
//
// Purpose: buffers incoming instructions and issues one per cycle into the
// 4-stage reg-read/ALU/regbank/membank pipeline, inserting bubbles while a
// source register is still being produced (the pipeline has no forwarding).
// Ports:
//   clk1, rst_n                 phase-1 clock, asynchronous active-low reset
//   in_valid/in_ready, in_*     instruction offer interface
//   flush                       drop all buffered instructions
//   iss_valid, rs1/rs2/rd/func/addr  registered pipeline operands
//   stall                       head present but blocked by a hazard
//   count                       FIFO occupancy
//   iss_cnt, stall_cnt          saturating statistics (PIPE_ISSUE_STATS_EN only)
// Build option: PIPE_ISSUE_STATS_EN adds the statistics counters.
module pipe_issue_unit
  import pipe_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HAZ_WIN    = 2
) (
  input  logic                          clk1,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [REG_W-1:0]              in_rs1,
  input  logic [REG_W-1:0]              in_rs2,
  input  logic [REG_W-1:0]              in_rd,
  input  logic [3:0]                    in_func,
  input  logic [ADDR_W-1:0]             in_addr,
  input  logic                          flush,
  output logic                          iss_valid,
  output logic [REG_W-1:0]              rs1,
  output logic [REG_W-1:0]              rs2,
  output logic [REG_W-1:0]              rd,
  output logic [3:0]                    func,
  output logic [ADDR_W-1:0]             addr,
  output logic                          stall,
  output logic [$clog2(FIFO_DEPTH):0]   count
`ifdef PIPE_ISSUE_STATS_EN
  ,
  output logic [15:0]                   iss_cnt,
  output logic [15:0]                   stall_cnt
`endif
);

  instr_t    in_instr;
  instr_t    head;
  logic      full;
  logic      empty;
  logic      hazard;
  logic      push;
  logic      pop;
  sb_entry_t sb [HAZ_WIN];

  assign in_instr = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                      func: alu_op_e'(in_func), addr: in_addr};

  assign in_ready = !full;
  assign push     = in_valid && !full && !flush;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (sb_hit(sb[i], head.rs1, head.rs2)) hazard = 1'b1;
    end
  end

  assign stall = !empty && hazard;
  assign pop   = !empty && !hazard && !flush;

  pipe_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk1),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (in_instr),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Operands hold across bubbles; only iss_valid marks a real instruction.
  // The scoreboard shifts every edge, flush included, so in-flight
  // destinations age out on schedule regardless of buffer activity.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      func      <= '0;
      addr      <= '0;
      for (int i = 0; i < HAZ_WIN; i++) sb[i] <= '0;
    end else begin
      iss_valid <= pop;
      if (pop) begin
        rs1  <= head.rs1;
        rs2  <= head.rs2;
        rd   <= head.rd;
        func <= head.func;
        addr <= head.addr;
      end
      sb[0] <= '{v: pop, rd: head.rd};
      for (int i = 1; i < HAZ_WIN; i++) sb[i] <= sb[i-1];
    end
  end

`ifdef PIPE_ISSUE_STATS_EN
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      iss_cnt   <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      iss_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop && (iss_cnt != 16'hFFFF))     iss_cnt   <= iss_cnt + 16'd1;
      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_issue_unit.sv
// tb/tb_pipe_issue_unit.sv - self-checking bench for pipe_issue_unit
module tb_pipe_issue_unit;
  import pipe_pkg::*;

  localparam int DEPTH = 4;
  localparam int HW    = 2;

  logic       clk1 = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0, in_func = '0;
  logic [7:0] in_addr = '0;
  logic       in_ready, iss_valid, stall;
  logic [3:0] rs1, rs2, rd, func;
  logic [7:0] addr;
  logic [2:0] count;
`ifdef PIPE_ISSUE_STATS_EN
  logic [15:0] iss_cnt, stall_cnt;
`endif

  pipe_issue_unit #(.FIFO_DEPTH(DEPTH), .HAZ_WIN(HW)) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .in_func   (in_func),
    .in_addr   (in_addr),
    .flush     (flush),
    .iss_valid (iss_valid),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .func      (func),
    .addr      (addr),
    .stall     (stall),
    .count     (count)
`ifdef PIPE_ISSUE_STATS_EN
    ,
    .iss_cnt   (iss_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of pending instructions plus the edge number
  // at which each register was last issued as a destination.
  instr_t q[$];
  instr_t m_out;
  int     last_iss [16];
  int     edge_n = 0;
  int     m_iss_cnt = 0;
  int     m_stall_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_out = '0;
    for (int i = 0; i < 16; i++) last_iss[i] = -100;
    m_iss_cnt = 0;
    m_stall_cnt = 0;
  endtask

  // Called at a falling edge; drives one cycle of stimulus and checks the
  // combinational status before the edge and the registered outputs after.
  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] d, input logic [3:0] f,
                      input logic [7:0] ad, input logic fl);
    instr_t h;
    logic   blk;
    logic   iss;
    int     n;
    in_valid = v; in_rs1 = a; in_rs2 = b; in_rd = d; in_func = f;
    in_addr = ad; flush = fl;
    n   = q.size();
    blk = 1'b0;
    if (n > 0) begin
      h   = q[0];
      blk = ((edge_n - last_iss[h.rs1]) <= HW) || ((edge_n - last_iss[h.rs2]) <= HW);
    end
    #1;
    check_eq("count", 32'(count), 32'(n));
    check_eq("in_ready", 32'(in_ready), 32'(n < DEPTH));
    check_eq("stall", 32'(stall), 32'(n > 0 && blk));
    iss = !fl && (n > 0) && !blk;
    if (fl) begin
      q.delete();
      m_iss_cnt = 0;
      m_stall_cnt = 0;
    end else begin
      if (iss) begin
        m_out = q.pop_front();
        last_iss[m_out.rd] = edge_n;
        if (m_iss_cnt < 65535) m_iss_cnt++;
      end
      if (n > 0 && blk && m_stall_cnt < 65535) m_stall_cnt++;
      if (v && n < DEPTH)
        q.push_back('{rs1: a, rs2: b, rd: d, func: alu_op_e'(f), addr: ad});
    end
    edge_n++;
    @(posedge clk1);
    #1;
    check_eq("iss_valid", 32'(iss_valid), 32'(iss));
    check_eq("rs1", 32'(rs1), 32'(m_out.rs1));
    check_eq("rs2", 32'(rs2), 32'(m_out.rs2));
    check_eq("rd", 32'(rd), 32'(m_out.rd));
    check_eq("func", 32'(func), 32'(m_out.func));
    check_eq("addr", 32'(addr), 32'(m_out.addr));
`ifdef PIPE_ISSUE_STATS_EN
    check_eq("iss_cnt", 32'(iss_cnt), 32'(m_iss_cnt));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
`endif
    @(negedge clk1);
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0, 1'b0);
  endtask

  // Producer writing r10 followed by three consumers of r10: leaves three
  // entries queued behind the hazard.
  task automatic fill_three();
    step(1'b1, 4'd3, 4'd5, 4'd10, 4'd0, 8'd1, 1'b0);
    step(1'b1, 4'd10, 4'd1, 4'd1, 4'd5, 8'd2, 1'b0);
    step(1'b1, 4'd10, 4'd2, 4'd2, 4'd6, 8'd3, 1'b0);
    step(1'b1, 4'd10, 4'd4, 4'd3, 4'd7, 8'd4, 1'b0);
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_iss_valid", 32'(iss_valid), 32'd0);
    check_eq("rst_operands", {12'd0, rs1, rs2, rd, func, addr}, 32'd0);
`ifdef PIPE_ISSUE_STATS_EN
    check_eq("rst_stats", {iss_cnt, stall_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(negedge clk1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    check_eq("reset_count", 32'(count), 32'd0);
    check_eq("reset_iss_valid", 32'(iss_valid), 32'd0);
    check_eq("reset_operands", {12'd0, rs1, rs2, rd, func, addr}, 32'd0);
    check_eq("reset_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk1);

    // Independent stream: back-to-back issue.
    step(1'b1, 4'd3, 4'd5, 4'd10, 4'd0, 8'd125, 1'b0);
    step(1'b1, 4'd3, 4'd8, 4'd12, 4'd2, 8'd126, 1'b0);
    step(1'b1, 4'd7, 4'd3, 4'd13, 4'd11, 8'd127, 1'b0);
    idle(4);

    // RAW: SUB waits two bubbles behind ADD.
    step(1'b1, 4'd3, 4'd5, 4'd10, 4'd0, 8'd0, 1'b0);
    step(1'b1, 4'd10, 4'd5, 4'd14, 4'd1, 8'd0, 1'b0);
    idle(5);

    // Full: dependent chain on r10 fills the buffer, extra pushes dropped.
    step(1'b1, 4'd3, 4'd5, 4'd10, 4'd0, 8'd1, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b1, 4'd10, 4'd10, 4'd10, 4'd3, 8'(8'd2 + 8'(i)), 1'b0);
    idle(20);

    // Flush with three queued entries and a concurrent push.
    fill_three();
    step(1'b1, 4'd1, 4'd2, 4'd3, 4'd0, 8'd99, 1'b1);
    step(1'b1, 4'd4, 4'd5, 4'd6, 4'd0, 8'd77, 1'b0);
    idle(3);

    // Reset in the middle of a stream holding three entries.
    fill_three();
    mid_reset();
    idle(2);

`ifdef PIPE_ISSUE_STATS_EN
    step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0, 1'b1);
    step(1'b1, 4'd3, 4'd5, 4'd10, 4'd0, 8'd0, 1'b0);
    step(1'b1, 4'd10, 4'd5, 4'd14, 4'd1, 8'd0, 1'b0);
    idle(5);
    check_eq("stats_iss_cnt", 32'(iss_cnt), 32'd2);
    check_eq("stats_stall_cnt", 32'(stall_cnt), 32'd2);
`endif

    // Random traffic over a narrow register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      step(1'($urandom_range(0, 99) < 70),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 11)),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 99) < 4));
    end
    idle(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
